// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : posit_pkg
// Purpose  : Shared posit definitions used by both the decode and encode
//            sides of the posit datapath: operand class codes, default
//            format widths and helpers that build the special bit patterns.
// Revision : 1.0 - initial release
// ============================================================================
package posit_pkg;

  // Operand class codes; 2'b11 is treated as NaR wherever it is seen.
  localparam logic [1:0] CLS_ZERO = 2'b00;
  localparam logic [1:0] CLS_VLD  = 2'b01;
  localparam logic [1:0] CLS_NAR  = 2'b10;

  // Default posit format.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_EXP   = 2;
  localparam int DEF_FRAC  = 8;

  // Helpers return a 32-bit container; callers keep the low w bits.
  function automatic logic [31:0] maxpos(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] minpos(input int unsigned w);
    return (w > 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] nar(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_encoder_round.sv
`default_nettype none
// ============================================================================
// Module   : posit_round
// Purpose  : Round-to-nearest-even on the truncated posit body (sign bit
//            excluded), clamped so the result never becomes zero and never
//            carries out of maxpos into the NaR pattern.
// Ports    : p_i      - truncated body, PW bits
//            guard_i  - first discarded bit
//            sticky_i - OR of every bit below the guard
//            p_o      - rounded, clamped body
// Revision : 1.0 - initial release
// ============================================================================
module posit_round #(
  parameter int PW = 7
) (
  input  logic [PW-1:0] p_i,
  input  logic          guard_i,
  input  logic          sticky_i,
  output logic [PW-1:0] p_o
);

  logic          round_up;
  logic [PW-1:0] p_inc;

  always_comb begin
    round_up = guard_i & (sticky_i | p_i[0]);
    p_inc    = p_i + {{(PW-1){1'b0}}, round_up};
    if (&p_i) begin
      // maxpos absorbs any round-up instead of wrapping toward NaR
      p_o = p_i;
    end else if (p_inc == '0) begin
      p_o = {{(PW-1){1'b0}}, 1'b1};
    end else begin
      p_o = p_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/posit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : posit_encoder
// Purpose  : Two-stage pipelined posit encoder. Packs sign / signed regime /
//            exponent / fraction / sticky into a WIDTH-bit posit with RNE
//            rounding, maxpos/minpos saturation, zero and NaR handling.
// Ports    : clk_i, rstn (async, active low)
//            vld_i/rdy_o           - input handshake
//            cls_i, sign_i, regi_i, exp_i, mts_i, sticky_i - operand fields
//            vld_o/rdy_i, posit_o  - output handshake and encoded word
// Revision : 1.0 - initial release
// ============================================================================
module posit_encoder
  import posit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP   = DEF_EXP,
  parameter int FRAC  = DEF_FRAC,
  parameter int REGI  = $clog2(WIDTH) + 2
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             vld_i,
  output logic             rdy_o,
  input  logic [1:0]       cls_i,
  input  logic             sign_i,
  input  logic [REGI-1:0]  regi_i,
  input  logic [EXP-1:0]   exp_i,
  input  logic [FRAC-1:0]  mts_i,
  input  logic             sticky_i,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] posit_o
);

  localparam int PW = WIDTH - 1;          // body width, sign excluded
  localparam int TW = PW + 1 + EXP + FRAC; // room for longest regime + fields

  localparam logic [31:0] MAXPOS_W = maxpos(WIDTH);
  localparam logic [31:0] MINPOS_W = minpos(WIDTH);
  localparam logic [31:0] NAR_W    = nar(WIDTH);

  localparam logic signed [REGI-1:0] K_HI = REGI'(WIDTH - 2);
  localparam logic signed [REGI-1:0] K_LO = -K_HI;

  // ---------------- stage registers ----------------
  logic             s1_vld_q, s1_vld_d;
  logic [PW-1:0]    s1_p_q, s1_p_d;
  logic             s1_grd_q, s1_grd_d;
  logic             s1_stk_q, s1_stk_d;
  logic             s1_sgn_q, s1_sgn_d;
  logic [1:0]       s1_cls_q, s1_cls_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_posit_q, s2_posit_d;

  logic s1_load;
  logic s2_load;

  // ---------------- stage 1: regime build and truncate ----------------
  logic            k_neg;
  logic [REGI-1:0] run;
  logic [TW-1:0]   body;
  logic [TW-1:0]   shifted;
  logic            sat_hi;
  logic            sat_lo;
  logic [PW-1:0]   p_n;
  logic            grd_n;
  logic            stk_n;

  always_comb begin
    k_neg = regi_i[REGI-1];
    run   = k_neg ? (-regi_i) : (regi_i + REGI'(1));
    // Terminating regime bit sits on top of the fields; shifting right by
    // the run length fills the leading run with ones (k >= 0) or zeros.
    body    = {k_neg, exp_i, mts_i, {PW{1'b0}}};
    shifted = k_neg ? (body >> run) : ~((~body) >> run);
    sat_hi  = ($signed(regi_i) >= K_HI);
    sat_lo  = ($signed(regi_i) <  K_LO);
    if (sat_hi) begin
      p_n   = MAXPOS_W[PW-1:0];
      grd_n = 1'b0;
      stk_n = 1'b0;
    end else if (sat_lo) begin
      p_n   = MINPOS_W[PW-1:0];
      grd_n = 1'b0;
      stk_n = 1'b0;
    end else begin
      p_n   = shifted[TW-1 -: PW];
      grd_n = shifted[TW-1-PW];
      stk_n = (|shifted[TW-2-PW:0]) | sticky_i;
    end
  end

  // ---------------- stage 2: round, sign, class ----------------
  logic [PW-1:0]    p_rnd;
  logic [WIDTH-1:0] pos_word;
  logic [WIDTH-1:0] fin_word;

  posit_round #(.PW(PW)) u_round (
    .p_i      (s1_p_q),
    .guard_i  (s1_grd_q),
    .sticky_i (s1_stk_q),
    .p_o      (p_rnd)
  );

  always_comb begin
    pos_word = {1'b0, p_rnd};
    case (s1_cls_q)
      CLS_ZERO: fin_word = '0;
      CLS_VLD:  fin_word = s1_sgn_q ? (-pos_word) : pos_word;
      default:  fin_word = NAR_W[WIDTH-1:0];
    endcase
  end

  // ---------------- pipeline control ----------------
  always_comb begin
    s2_load    = ~s2_vld_q | rdy_i;
    s1_load    = ~s1_vld_q | s2_load;

    s1_vld_d   = s1_vld_q;
    s1_p_d     = s1_p_q;
    s1_grd_d   = s1_grd_q;
    s1_stk_d   = s1_stk_q;
    s1_sgn_d   = s1_sgn_q;
    s1_cls_d   = s1_cls_q;
    s2_vld_d   = s2_vld_q;
    s2_posit_d = s2_posit_q;

    if (s1_load) begin
      s1_vld_d = vld_i;
      if (vld_i) begin
        s1_p_d   = p_n;
        s1_grd_d = grd_n;
        s1_stk_d = stk_n;
        s1_sgn_d = sign_i;
        s1_cls_d = cls_i;
      end
    end

    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_posit_d = fin_word;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q   <= 1'b0;
      s1_p_q     <= '0;
      s1_grd_q   <= 1'b0;
      s1_stk_q   <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s2_vld_q   <= 1'b0;
      s2_posit_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_p_q     <= s1_p_d;
      s1_grd_q   <= s1_grd_d;
      s1_stk_q   <= s1_stk_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_cls_q   <= s1_cls_d;
      s2_vld_q   <= s2_vld_d;
      s2_posit_q <= s2_posit_d;
    end
  end

  assign rdy_o   = s1_load;
  assign vld_o   = s2_vld_q;
  assign posit_o = s2_posit_q;

endmodule
`default_nettype wire
